render_scheduler: RTL and testbench

- Frame-level sequencer between the game-state block (runner) and the pixel blitter.
- Once per frame period it clears the back buffer, then walks all render slots in index order (0 = back, SLOTS-1 = front).
- Each visible slot's sprite and position are issued to the blitter over a valid/ready handshake.
- After the blitter drains it swaps buffers and raises painter_finished, whose rising edge steps the game loop.

---
 rtl/render_scheduler.sv | 154 +++++++++++++++
 tb/tb_render_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/render_scheduler.sv
// render_scheduler: per-frame sequencer that clears the back buffer, issues visible
// slots to the blitter in index order, waits for drain, then swaps buffers.
module render_scheduler #(
    parameter int SLOTS        = 32,
    parameter int FRAME_CYCLES = 555555,
    parameter int SCREEN_W     = 1280,
    parameter int SCREEN_H     = 300
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SLOTS-1:0][47:0]     sprite,
    input  logic [SLOTS-1:0][23:0]     pos,
    output logic                       clear_valid,
    input  logic                       clear_ready,
    output logic                       blit_valid,
    input  logic                       blit_ready,
    output logic [11:0]                blit_src_x,
    output logic [11:0]                blit_src_y,
    output logic [11:0]                blit_w,
    output logic [11:0]                blit_h,
    output logic [11:0]                blit_dst_x,
    output logic [11:0]                blit_dst_y,
    input  logic                       blit_busy,
    output logic                       swap,
    output logic                       painter_finished,
    output logic [7:0]                 overrun_count,
    output logic [$clog2(SLOTS)-1:0]   slot_index
);
    localparam int SW = $clog2(SLOTS);
    localparam int CW = $clog2(FRAME_CYCLES);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, ISSUE, FLUSH, SWAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [7:0]      ovr_q, ovr_d;
    logic [47:0]     spr_q, spr_d;
    logic [23:0]     dst_q, dst_d;
    logic            pending_q, pending_d;
    logic            clear_valid_q, clear_valid_d;
    logic            blit_valid_q, blit_valid_d;
    logic            swap_q, swap_d;
    logic            pf_q, pf_d;
    logic            tick, last, visible;
    logic [47:0]     cur_spr;
    logic [23:0]     cur_pos;
    logic signed [13:0] dx, dy, w, h;

    assign tick    = cnt_q == CW'(FRAME_CYCLES - 1);
    assign last    = slot_q == SW'(SLOTS - 1);
    assign cur_spr = sprite[slot_q];
    assign cur_pos = pos[slot_q];
    // Widened to 14 bits so dx + w cannot wrap for any 12-bit inputs.
    assign dx      = {{2{cur_pos[23]}}, cur_pos[23:12]};
    assign dy      = {{2{cur_pos[11]}}, cur_pos[11:0]};
    assign w       = {2'b00, cur_spr[23:12]};
    assign h       = {2'b00, cur_spr[11:0]};
    assign visible = (w != 14'sd0) && (h != 14'sd0) && (dx + w > 14'sd0) && (dy + h > 14'sd0)
                   && (dx < 14'(SCREEN_W)) && (dy < 14'(SCREEN_H));

    always_comb begin
        state_d       = state_q;
        cnt_d         = tick ? '0 : cnt_q + CW'(1);
        slot_d        = slot_q;
        ovr_d         = ovr_q;
        spr_d         = spr_q;
        dst_d         = dst_q;
        pending_d     = pending_q;
        clear_valid_d = clear_valid_q;
        blit_valid_d  = blit_valid_q;
        swap_d        = 1'b0;
        pf_d          = pf_q;
        if (tick && state_q != IDLE) begin
            pending_d = 1'b1;
            ovr_d     = ovr_q + {7'd0, ovr_q != 8'hff};
        end
        case (state_q)
            IDLE: if (tick || pending_q) begin
                state_d       = CLEAR;
                pending_d     = 1'b0;
                pf_d          = 1'b0;
                clear_valid_d = 1'b1;
            end
            CLEAR: if (clear_ready) begin
                clear_valid_d = 1'b0;
                slot_d        = '0;
                state_d       = SCAN;
            end
            SCAN: if (visible) begin
                spr_d        = cur_spr;
                dst_d        = cur_pos;
                blit_valid_d = 1'b1;
                state_d      = ISSUE;
            end else begin
                state_d = last ? FLUSH : SCAN;
                slot_d  = last ? slot_q : slot_q + SW'(1);
            end
            ISSUE: if (blit_ready) begin
                blit_valid_d = 1'b0;
                state_d      = last ? FLUSH : SCAN;
                slot_d       = last ? slot_q : slot_q + SW'(1);
            end
            FLUSH: if (!blit_busy) begin
                state_d = SWAP;
                swap_d  = 1'b1;
                pf_d    = 1'b1;
            end
            SWAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            slot_q        <= '0;
            ovr_q         <= '0;
            spr_q         <= '0;
            dst_q         <= '0;
            pending_q     <= 1'b0;
            clear_valid_q <= 1'b0;
            blit_valid_q  <= 1'b0;
            swap_q        <= 1'b0;
            pf_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            ovr_q         <= ovr_d;
            spr_q         <= spr_d;
            dst_q         <= dst_d;
            pending_q     <= pending_d;
            clear_valid_q <= clear_valid_d;
            blit_valid_q  <= blit_valid_d;
            swap_q        <= swap_d;
            pf_q          <= pf_d;
        end
    end

    assign clear_valid      = clear_valid_q;
    assign blit_valid       = blit_valid_q;
    assign swap             = swap_q;
    assign painter_finished = pf_q;
    assign overrun_count    = ovr_q;
    assign slot_index       = slot_q;
    assign blit_src_x       = spr_q[47:36];
    assign blit_src_y       = spr_q[35:24];
    assign blit_w           = spr_q[23:12];
    assign blit_h           = spr_q[11:0];
    assign blit_dst_x       = dst_q[23:12];
    assign blit_dst_y       = dst_q[11:0];
endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: scoreboard bench; a 200-cycle-frame instance for ordering/timing
// and a 20-cycle-frame instance with every slot visible for overrun accounting.
module tb_render_scheduler;
    localparam int S = 32;

    logic clk = 1'b0, rst = 1'b0;
    logic [S-1:0][47:0] sprite, sprite_o;
    logic [S-1:0][23:0] pos, pos_o;
    logic clear_ready = 1'b1, blit_ready = 1'b1, blit_busy = 1'b0;
    logic clear_valid, blit_valid, swap, pf;
    logic [11:0] o_sx, o_sy, o_w, o_h, o_dx, o_dy;
    logic [7:0] ovr;
    logic [4:0] slot_index;
    logic cv_o, bv_o, sw_o, pf_o;
    logic [11:0] p_sx, p_sy, p_w, p_h, p_dx, p_dy;
    logic [7:0] ovr_o;
    logic [4:0] si_o;

    render_scheduler #(.SLOTS(S), .FRAME_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .sprite(sprite), .pos(pos),
        .clear_valid(clear_valid), .clear_ready(clear_ready),
        .blit_valid(blit_valid), .blit_ready(blit_ready),
        .blit_src_x(o_sx), .blit_src_y(o_sy), .blit_w(o_w), .blit_h(o_h),
        .blit_dst_x(o_dx), .blit_dst_y(o_dy), .blit_busy(blit_busy),
        .swap(swap), .painter_finished(pf), .overrun_count(ovr), .slot_index(slot_index));

    render_scheduler #(.SLOTS(S), .FRAME_CYCLES(20)) dut_o (
        .clk(clk), .rst(rst), .sprite(sprite_o), .pos(pos_o),
        .clear_valid(cv_o), .clear_ready(1'b1),
        .blit_valid(bv_o), .blit_ready(1'b1),
        .blit_src_x(p_sx), .blit_src_y(p_sy), .blit_w(p_w), .blit_h(p_h),
        .blit_dst_x(p_dx), .blit_dst_y(p_dy), .blit_busy(1'b0),
        .swap(sw_o), .painter_finished(pf_o), .overrun_count(ovr_o), .slot_index(si_o));

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst) cyc <= !rst ? 0 : cyc + 1;

    int total = 0, bad = 0, nblits = 0;
    bit rnd_ready = 1'b0;
    logic [71:0] exp_q[$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference visibility rule in plain integer arithmetic.
    function automatic bit vis(input logic [47:0] s, input logic [23:0] p);
        int x = $signed(p[23:12]);
        int y = $signed(p[11:0]);
        int w = s[23:12];
        int h = s[11:0];
        return w != 0 && h != 0 && x + w > 0 && y + h > 0 && x < 1280 && y < 300;
    endfunction

    task automatic push_frame();
        for (int i = 0; i < S; i++) if (vis(sprite[i], pos[i])) exp_q.push_back({sprite[i], pos[i]});
    endtask

    // Back-to-back frames of 67 busy cycles (32 visible slots, no stalls) then one IDLE cycle;
    // every tick inside a busy window is an overrun, visible one cycle later.
    function automatic int exp_ovr(input int n);
        int s = 20, tot = 0, e;
        while (1) begin
            e = s + 66;
            for (int t = s; t <= e; t++) if (t < n && t % 20 == 19) tot++;
            if (e + 2 >= n) break;
            s = e + 2;
        end
        return tot > 255 ? 255 : tot;
    endfunction

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_swap(input string nm);
        int k = 0;
        while (!swap && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " swap"}, swap, 1'b1);
        chk({nm, " drained"}, 72'(exp_q.size()), 72'd0);
    endtask

    always @(negedge clk) begin
        if (rst && blit_valid && blit_ready) begin
            nblits++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL blit unexpected: got %0h want none", {o_sx, o_sy, o_w, o_h, o_dx, o_dy});
            end else chk("blit payload", {o_sx, o_sy, o_w, o_h, o_dx, o_dy}, exp_q.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) blit_ready = ($urandom % 4) != 0;
    end

    initial begin
        int cps[4] = '{300, 1500, 4000, 6000};
        foreach (cps[i]) begin
            while (cyc != cps[i]) @(negedge clk);
            chk($sformatf("overrun@%0d", cps[i]), ovr_o, 72'(exp_ovr(cps[i])));
        end
    end

    initial begin
        int bx[4] = '{-100, -99, 0, 0};
        int by[4] = '{0, 0, 300, 299};
        int bwv[4] = '{100, 100, 10, 10};
        int bn[4] = '{0, 1, 0, 1};
        int t, n0, k;
        sprite = '0;
        pos = '0;
        pos_o = '0;
        for (int i = 0; i < S; i++) sprite_o[i] = {12'd0, 12'd0, 12'd8, 12'd8};
        #22;
        chk("rst clear_valid", clear_valid, 0);
        chk("rst blit_valid", blit_valid, 0);
        chk("rst swap", swap, 0);
        chk("rst painter_finished", pf, 0);
        chk("rst overrun", ovr, 0);
        chk("rst slot_index", slot_index, 0);
        @(negedge clk);
        rst = 1'b1;
        to_cyc(199);
        chk("f0 pre-tick clear", clear_valid, 0);
        to_cyc(200);
        chk("f0 clear", clear_valid, 1);
        to_cyc(233);
        chk("f0 pf early", pf, 0);
        chk("f0 swap early", swap, 0);
        to_cyc(234);
        chk("f0 swap", swap, 1);
        chk("f0 pf", pf, 1);
        to_cyc(235);
        chk("f0 swap one cycle", swap, 0);
        chk("f0 pf held", pf, 1);
        chk("f0 no blits", 72'(nblits), 0);
        sprite[0] = {12'd5, 12'd6, 12'd7, 12'd8};
        pos[0] = {12'd20, 12'd30};
        sprite[18] = {12'd1678, 12'd2, 12'd88, 12'd94};
        pos[18] = {12'd100, 12'd186};
        push_frame();
        to_cyc(420);
        @(posedge clk);
        #1 blit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall valid", blit_valid, 1);
            chk("stall slot", slot_index, 18);
            chk("stall payload", {o_sx, o_sy, o_w, o_h, o_dx, o_dy},
                {12'd1678, 12'd2, 12'd88, 12'd94, 12'd100, 12'd186});
            if (i == 0) begin
                sprite[18] = {12'd9, 12'd9, 12'd9, 12'd9};
                pos[18] = {12'd1, 12'd1};
            end
        end
        @(posedge clk);
        #1 blit_ready = 1'b1;
        wait_swap("f1");
        chk("f1 swap cycle", 72'(cyc), 72'd439);
        chk("f1 transfers", 72'(nblits), 72'd2);
        foreach (bx[j]) begin
            sprite = '0;
            pos = '0;
            sprite[11] = {12'd3, 12'd4, 12'(bwv[j]), 12'd10};
            pos[11] = {12'(bx[j]), 12'(by[j])};
            push_frame();
            n0 = nblits;
            @(negedge clk);
            wait_swap($sformatf("edge%0d", j));
            chk($sformatf("edge%0d count", j), 72'(nblits - n0), 72'(bn[j]));
        end
        sprite = '0;
        pos = '0;
        sprite[31] = {12'd7, 12'd7, 12'd16, 12'd16};
        pos[31] = {12'd640, 12'd150};
        push_frame();
        t = (cyc / 200 + 1) * 200 - 1;
        to_cyc(t + 34);
        @(posedge clk);
        #1 blit_busy = 1'b1;
        repeat (50) @(posedge clk);
        #1 blit_busy = 1'b0;
        @(negedge clk);
        chk("busy swap held", swap, 0);
        chk("busy pf held", pf, 0);
        @(negedge clk);
        chk("busy swap", swap, 1);
        chk("busy pf", pf, 1);
        chk("busy drained", 72'(exp_q.size()), 0);
        rnd_ready = 1'b1;
        while (cyc < 6100) begin
            for (int i = 0; i < S; i++) begin
                sprite[i] = {12'($urandom), 12'($urandom),
                             ($urandom % 3 == 0) ? 12'd0 : 12'($urandom_range(1, 1023)),
                             12'($urandom_range(0, 200))};
                pos[i] = {12'($urandom_range(0, 2600) - 1200), 12'($urandom_range(0, 700) - 350)};
            end
            push_frame();
            @(negedge clk);
            wait_swap("random");
        end
        rnd_ready = 1'b0;
        @(negedge clk);
        blit_ready = 1'b1;
        chk("main no overrun", ovr, 0);
        sprite = '0;
        pos = '0;
        sprite[0] = {12'd1, 12'd2, 12'd3, 12'd4};
        pos[0] = {12'd5, 12'd6};
        blit_ready = 1'b0;
        k = 0;
        while (!blit_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("pre-reset valid", blit_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async blit_valid", blit_valid, 0);
        chk("async pf", pf, 0);
        chk("async swap", swap, 0);
        chk("async slot", slot_index, 0);
        chk("async overrun_o", ovr_o, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        blit_ready = 1'b1;
        push_frame();
        to_cyc(199);
        chk("post-reset idle", clear_valid, 0);
        to_cyc(200);
        chk("post-reset clear", clear_valid, 1);
        wait_swap("post-reset");
        chk("post-reset swap cycle", 72'(cyc), 72'd235);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
